// File: rtl/task_pingpong_latency.sv
// Runs NUM_ROUNDS ping/pong exchanges, one result word per round; stalls in EMIT until i_ready.
// Define TASK_PINGPONG_STATS_EN to append a min/max/timeout-count word after the last round.
module task_pingpong_latency #(
  parameter int TASK_OUTPUT_WIDTH = 32,
  parameter int NUM_ROUNDS        = 8,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         ping_ready,
  output logic                         ping,
  input  logic                         pong,
  input  logic                         i_ready,
  output logic [TASK_OUTPUT_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_last,
  output logic                         o_busy
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [7:0]           LAST_ROUND  = 8'(NUM_ROUNDS - 1);

`ifdef TASK_PINGPONG_STATS_EN
  typedef enum logic [2:0] {IDLE, WAIT_READY, WAIT_PONG, EMIT, STATS} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_READY, WAIT_PONG, EMIT} state_t;
`endif

  state_t                         state;
  logic [7:0]                     round_idx;
  logic [CNT_WIDTH-1:0]           cnt;
  logic [CNT_WIDTH-1:0]           cnt_next;
  logic                           round_done;
  logic [TASK_OUTPUT_WIDTH-1:0]   round_word;

  // Counter saturates so a timeout larger than the pong window can never wrap.
  assign cnt_next   = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  assign round_done = pong || (cnt_next == TIMEOUT_VAL);

  always_comb begin
    round_word                          = '0;
    round_word[TASK_OUTPUT_WIDTH-1]     = ~pong;
    round_word[TASK_OUTPUT_WIDTH-2 -: 8] = round_idx;
    round_word[CNT_WIDTH-1:0]           = cnt_next;
  end

`ifdef TASK_PINGPONG_STATS_EN
  logic [CNT_WIDTH-1:0]         min_lat;
  logic [CNT_WIDTH-1:0]         max_lat;
  logic [7:0]                   to_cnt;
  logic                         any_ok;
  logic [TASK_OUTPUT_WIDTH-1:0] stats_word;

  always_comb begin
    stats_word = '0;
    // Payload below the flag/tag byte; truncates min and the count when the word is narrow.
    stats_word[TASK_OUTPUT_WIDTH-10:0] = (TASK_OUTPUT_WIDTH-9)'({to_cnt,
                                           (any_ok ? min_lat : '0), max_lat});
    stats_word[TASK_OUTPUT_WIDTH-1]      = 1'b1;
    stats_word[TASK_OUTPUT_WIDTH-2 -: 8] = 8'hFF;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min_lat <= '1;
      max_lat <= '0;
      to_cnt  <= '0;
      any_ok  <= 1'b0;
    end else if (state == IDLE && i_start) begin
      min_lat <= '1;
      max_lat <= '0;
      to_cnt  <= '0;
      any_ok  <= 1'b0;
    end else if (state == WAIT_PONG) begin
      if (pong) begin
        any_ok <= 1'b1;
        if (cnt_next < min_lat) min_lat <= cnt_next;
        if (cnt_next > max_lat) max_lat <= cnt_next;
      end else if (cnt_next == TIMEOUT_VAL && to_cnt != 8'hFF) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      round_idx <= '0;
      cnt       <= '0;
      ping      <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            round_idx <= '0;
            o_busy    <= 1'b1;
            state     <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (ping_ready) begin
            ping  <= 1'b1;
            cnt   <= '0;
            state <= WAIT_PONG;
          end
        end
        WAIT_PONG: begin
          ping <= 1'b0;
          cnt  <= cnt_next;
          if (round_done) begin
            o_data  <= round_word;
            o_valid <= 1'b1;
`ifdef TASK_PINGPONG_STATS_EN
            o_last  <= 1'b0;
`else
            o_last  <= (round_idx == LAST_ROUND);
`endif
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (round_idx == LAST_ROUND) begin
`ifdef TASK_PINGPONG_STATS_EN
              o_data  <= stats_word;
              o_valid <= 1'b1;
              o_last  <= 1'b1;
              state   <= STATS;
`else
              o_busy  <= 1'b0;
              state   <= IDLE;
`endif
            end else begin
              round_idx <= round_idx + 8'd1;
              state     <= WAIT_READY;
            end
          end
        end
`ifdef TASK_PINGPONG_STATS_EN
        STATS: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_pingpong_latency.sv
// Directed bench for task_pingpong_latency acting as peer and downstream sink.
module tb_task_pingpong_latency;
  localparam int W  = 32;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam int CW = 8;
`ifdef TASK_PINGPONG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic         ping_ready;
  logic         ping;
  logic         pong;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_last;
  logic         o_busy;

  int compared   = 0;
  int mismatched = 0;

  task_pingpong_latency #(
    .TASK_OUTPUT_WIDTH(W),
    .NUM_ROUNDS(NR),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .ping_ready(ping_ready),
    .ping(ping),
    .pong(pong),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_last(o_last),
    .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // lat = 0 means the peer never answers (timeout round).
  task automatic do_round(input int lat, input int rnd, input bit is_last,
                          input int rdy_stall, input int pr_stall);
    int n;
    bit bad;
    int exp_lat;
    logic to;
    logic [31:0] w;
    to      = (lat == 0);
    exp_lat = to ? TO : lat;
    if (pr_stall > 0) begin
      ping_ready = 1'b0;
      bad = 1'b0;
      repeat (pr_stall) begin
        @(negedge i_clk);
        if (ping) bad = 1'b1;
      end
      chk("no_ping_while_not_ready", 32'(bad), 32'd0);
      ping_ready = 1'b1;
      @(negedge i_clk);
      chk("ping_after_ready", 32'(ping), 32'd1);
    end else begin
      n = 0;
      while (!ping && n < 20) begin
        @(negedge i_clk);
        n++;
      end
      chk("ping_seen", 32'(ping), 32'd1);
    end
    n   = 0;
    bad = 1'b0;
    while (1) begin
      if (lat > 0 && n == lat - 1) pong = 1'b1;
      @(negedge i_clk);
      n++;
      pong = 1'b0;
      if (ping) bad = 1'b1;
      if (o_valid || n >= 100) break;
    end
    chk("ping_one_cycle", 32'(bad), 32'd0);
    chk("cycles_to_valid", n, exp_lat);
    w = {to, 8'(rnd), 15'd0, 8'(exp_lat)};
    chk("o_data", o_data, w);
    chk("o_last", 32'(o_last), 32'(is_last && !STATS));
    chk("busy_in_emit", 32'(o_busy), 32'd1);
    if (rdy_stall > 0) begin
      bad = 1'b0;
      repeat (rdy_stall) begin
        @(negedge i_clk);
        if (!o_valid || o_data !== w || ping) bad = 1'b1;
      end
      chk("hold_under_backpressure", 32'(bad), 32'd0);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("valid_after_handshake", 32'(o_valid), 32'(is_last && STATS));
    if (is_last && !STATS) chk("idle_after_run", 32'(o_busy), 32'd0);
  endtask

`ifdef TASK_PINGPONG_STATS_EN
  task automatic do_stats(input logic [31:0] w);
    chk("stats_valid", 32'(o_valid), 32'd1);
    chk("stats_data", o_data, w);
    chk("stats_last", 32'(o_last), 32'd1);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("stats_valid_drop", 32'(o_valid), 32'd0);
    chk("stats_idle", 32'(o_busy), 32'd0);
  endtask
`endif

  task automatic start_run();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  initial begin
    int n;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    ping_ready = 1'b1;
    pong       = 1'b0;
    i_ready    = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ping", 32'(ping), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", o_data, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Run A: fixed latency 5, 20-cycle backpressure on round 1, stray i_start while busy.
    start_run();
    do_round(5, 0, 1'b0, 0, 0);
    i_start = 1'b1;
    do_round(5, 1, 1'b0, 20, 0);
    i_start = 1'b0;
    do_round(5, 2, 1'b0, 0, 0);
    do_round(5, 3, 1'b1, 0, 0);
`ifdef TASK_PINGPONG_STATS_EN
    do_stats(32'hFF80_0505);
`endif

    // Run B back-to-back: timeouts, with a ping_ready stall before round 2.
    start_run();
    do_round(0, 0, 1'b0, 0, 0);
    do_round(0, 1, 1'b0, 0, 0);
    do_round(4, 2, 1'b0, 0, 10);
    do_round(0, 3, 1'b1, 0, 0);
`ifdef TASK_PINGPONG_STATS_EN
    do_stats(32'hFF83_0404);
`endif

    // Run C: minimum latency, then reset in the middle of round 1's pong wait.
    start_run();
    do_round(1, 0, 1'b0, 0, 0);
    n = 0;
    while (!ping && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("ping_before_reset", 32'(ping), 32'd1);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", 32'(o_valid), 32'd0);
    chk("midrun_rst_busy", 32'(o_busy), 32'd0);
    chk("midrun_rst_data", o_data, 32'd0);
    chk("midrun_rst_last", 32'(o_last), 32'd0);
    @(negedge i_clk);
    chk("midrun_rst_ping", 32'(ping), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Run D: restarts at round 0 with latencies 3, 7, timeout, 5.
    start_run();
    do_round(3, 0, 1'b0, 0, 0);
    do_round(7, 1, 1'b0, 0, 0);
    do_round(0, 2, 1'b0, 0, 0);
    do_round(5, 3, 1'b1, 0, 0);
`ifdef TASK_PINGPONG_STATS_EN
    do_stats(32'hFF81_0307);
`endif

    repeat (2) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/task_pingpong_latency.md
Name: task_pingpong_latency

Overview:
- Parametrised successor to the fixed-pattern ping/pong task blocks.
- On i_start, runs NUM_ROUNDS ping/pong exchanges with the peer, measuring per-round latency in clock cycles, with a timeout per round.
- Streams one result word per round to the UART task output path (o_data/o_valid/o_last), honouring downstream backpressure via i_ready.

Parameters:
- TASK_OUTPUT_WIDTH, 32, output word width; must be >= CNT_WIDTH+9.
- NUM_ROUNDS, 8, ping/pong exchanges per run; range 1..256.
- TIMEOUT_CYCLES, 1024, cycles to wait for pong before declaring timeout; must be < 2**CNT_WIDTH.
- CNT_WIDTH, 16, width of the latency counter and the latency field.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_start  in  1  start a run; sampled only in IDLE
- ping_ready  in  1  peer can accept a ping
- ping  out  1  single-cycle ping pulse, registered
- pong  in  1  peer response; sampled only in WAIT_PONG
- i_ready  in  1  downstream accepts o_data when o_valid is high
- o_data  out  TASK_OUTPUT_WIDTH  result word
- o_valid  out  1  o_data valid
- o_last  out  1  final word of the run
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (while i_rst_n is low): state IDLE; ping, o_valid, o_last, o_busy = 0; o_data = 0; round index = 0; counter = 0.
- Reset mid-run aborts immediately. Any o_valid in progress is dropped. No partial o_last is issued.
- FSM states:
  - IDLE: if i_start, clear round index and go to WAIT_READY. o_busy goes high the next cycle.
  - WAIT_READY: stay while ping_ready is low. When ping_ready is high, go to WAIT_PONG and assert ping for exactly that next cycle. Clear the counter.
  - WAIT_PONG: ping is high only in the first cycle.
    - Each rising edge increments the counter, saturating at all-ones.
    - If pong is sampled high at the L-th edge after the edge that set ping, latency = L. The minimum is 1, when pong is high during the ping cycle. Go to EMIT with timeout = 0.
    - If the counter reaches TIMEOUT_CYCLES with no pong, go to EMIT with timeout = 1 and latency = TIMEOUT_CYCLES.
    - If pong and timeout occur on the same edge, pong wins.
  - EMIT: o_valid = 1 and o_data is held stable until i_ready. On the handshake edge:
    - if this is the last round, go to IDLE;
    - else increment the round index and go to WAIT_READY.
    - o_valid drops the cycle after the handshake.
- o_data format:
  - bit [TASK_OUTPUT_WIDTH-1] = timeout flag;
  - bits [TASK_OUTPUT_WIDTH-2 -: 8] = round index, 0-based;
  - bits [CNT_WIDTH-1:0] = latency;
  - all other bits = 0.
- o_last = 1 together with o_valid only on the word for round NUM_ROUNDS-1, or on the stats word when that feature is enabled.
- pong outside WAIT_PONG is ignored. A pong held high across rounds is counted only once it is sampled in the next WAIT_PONG.
- i_start while o_busy is high is ignored.
- Two back-to-back runs are allowed: i_start in the IDLE cycle directly after the last handshake starts a new run.

Optional Feature:
- Macro: TASK_PINGPONG_STATS_EN.
- Enabled:
  - Track min latency, max latency and timeout count across the run. Timeouts are excluded from min/max.
  - After the last round word, emit one extra word (state STATS, same handshake):
    - bit [TASK_OUTPUT_WIDTH-1] = 1; bits [TASK_OUTPUT_WIDTH-2 -: 8] = 8'hFF;
    - bits [CNT_WIDTH-1:0] = max latency; bits [2*CNT_WIDTH-1:CNT_WIDTH] = min latency, truncated if TASK_OUTPUT_WIDTH < 2*CNT_WIDTH+9; bits [2*CNT_WIDTH+7:2*CNT_WIDTH] = timeout count, included only if width allows.
    - o_last moves to this word. If all rounds timed out, min = max = 0.
- Disabled: no stats registers, no STATS state; o_last is on the last round word.

Test Plan:
- NUM_ROUNDS=4, ping_ready=1, peer raises pong 5 cycles after each ping -> 4 words, latency 5, rounds 0..3, timeout bit 0, o_last only on round 3; ping high exactly 1 cycle per round.
- pong never asserted, TIMEOUT_CYCLES=16 -> each word has timeout=1 and latency=16; exactly 16 cycles from ping to o_valid+1.
- i_ready held low 20 cycles during EMIT -> o_valid and o_data stable for all 20 cycles; no next ping until the handshake.
- ping_ready low for 10 cycles at round 2 -> no ping issued; ping follows 1 cycle after ping_ready rises; latency unaffected by the stall.
- i_rst_n pulsed low in WAIT_PONG of round 1, then i_start -> all outputs 0 during reset; new run restarts at round 0.
- TASK_PINGPONG_STATS_EN, latencies 3,7,timeout,5 -> 5 words; final word has max=7, min=3, timeout count=1, o_last=1.
